// File: rtl/cook_sequencer_pkg.sv
// Shared types and constants for the cooking program sequencer.
package cook_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        PAUSED,
        BEEP
    } state_t;

    localparam logic [6:0] MAX_MIN    = 7'd99;
    localparam logic [6:0] MAX_SEC    = 7'd59;
    localparam logic [3:0] MAX_PWR    = 4'd10;
    localparam logic [3:0] PWR_PERIOD = 4'd10;

    typedef struct packed {
        logic [6:0] min;
        logic [6:0] sec;
        logic [3:0] pwr;
    } stage_t;

    // Saturate a raw table write to the legal minute/second/power ranges
    function automatic stage_t clamp_stage(input logic [6:0] m,
                                           input logic [6:0] s,
                                           input logic [3:0] p);
        stage_t r;
        r.min = (m > MAX_MIN) ? MAX_MIN : m;
        r.sec = (s > MAX_SEC) ? MAX_SEC : s;
        r.pwr = (p > MAX_PWR) ? MAX_PWR : p;
        return r;
    endfunction

    // A stage with no time programmed terminates the program
    function automatic logic stage_empty(input stage_t st);
        return (st.min == 7'd0) && (st.sec == 7'd0);
    endfunction

endpackage

// File: rtl/cook_sequencer_sec_tick_gen.sv
// Free-running prescaler producing a one-cycle strobe once per second.
module sec_tick_gen #(
    parameter int TICKS_PER_SEC = 100_000_000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(TICKS_PER_SEC - 1));

    // Wrap the prescaler on every tick; it never restarts for state changes
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/cook_sequencer.sv
// Multi-stage cooking program controller driving the countdown timer,
// the duty-cycled magnetron enable and the end-of-program beep.
module cook_sequencer
    import cook_sequencer_pkg::*;
#(
    parameter int NUM_STAGES    = 4,
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int LOAD_WAIT_SEC = 2,
    parameter int BEEP_SEC      = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_STAGES)-1:0] cfg_idx,
    input  logic [6:0]                    cfg_min,
    input  logic [6:0]                    cfg_sec,
    input  logic [3:0]                    cfg_pwr,
    input  logic                          start_p,
    input  logic                          pause_p,
    input  logic                          stop_p,
    input  logic                          door_open,
    input  logic                          tmr_done,
    output logic [6:0]                    tmr_min,
    output logic [6:0]                    tmr_sec,
    output logic                          tmr_start,
    output logic                          tmr_pause,
    output logic                          tmr_stop,
    output logic                          mag_en,
    output logic [$clog2(NUM_STAGES)-1:0] stage,
    output logic                          busy,
    output logic                          beep
);

    localparam int IDX_W   = $clog2(NUM_STAGES);
    localparam int SEC_MAX = (LOAD_WAIT_SEC > BEEP_SEC) ? LOAD_WAIT_SEC : BEEP_SEC;
    localparam int SEC_W   = (SEC_MAX > 1) ? $clog2(SEC_MAX) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STAGES - 1);
    localparam logic [SEC_W-1:0] LOAD_LAST = SEC_W'(LOAD_WAIT_SEC - 1);
    localparam logic [SEC_W-1:0] BEEP_LAST = SEC_W'(BEEP_SEC - 1);

    stage_t           table_q [NUM_STAGES];
    state_t           state_q, state_d;
    logic [IDX_W-1:0] stage_q, stage_d;
    logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;
    logic [3:0]       phase_q, phase_d;
    logic             done_q, door_q;
    logic             tick;

    logic [6:0]       tmr_min_d, tmr_sec_d;
    logic             tmr_start_d, tmr_pause_d, tmr_stop_d, mag_en_d, beep_d;

    logic             done_rise, door_rise, has_next;
    logic [IDX_W-1:0] next_idx;

    sec_tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tick (
        .clock(clock),
        .reset(reset),
        .tick (tick)
    );

    assign done_rise = tmr_done && !done_q;
    assign door_rise = door_open && !door_q;
    assign next_idx  = stage_q + IDX_W'(1);
    assign has_next  = (stage_q != LAST_IDX) && !stage_empty(table_q[next_idx]);
    assign busy      = (state_q != IDLE);
    assign stage     = stage_q;

    // State, counters, stage table and registered timer/magnetron outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            stage_q   <= '0;
            sec_cnt_q <= '0;
            phase_q   <= '0;
            done_q    <= 1'b0;
            door_q    <= 1'b0;
            tmr_min   <= '0;
            tmr_sec   <= '0;
            tmr_start <= 1'b0;
            tmr_pause <= 1'b0;
            tmr_stop  <= 1'b0;
            mag_en    <= 1'b0;
            beep      <= 1'b0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            sec_cnt_q <= sec_cnt_d;
            phase_q   <= phase_d;
            done_q    <= tmr_done;
            door_q    <= door_open;
            tmr_min   <= tmr_min_d;
            tmr_sec   <= tmr_sec_d;
            tmr_start <= tmr_start_d;
            tmr_pause <= tmr_pause_d;
            tmr_stop  <= tmr_stop_d;
            mag_en    <= mag_en_d;
            beep      <= beep_d;
            if (cfg_we && (state_q == IDLE)) begin
                table_q[cfg_idx] <= clamp_stage(cfg_min, cfg_sec, cfg_pwr);
            end
        end
    end

    // Next state with event priority stop > done edge > pause/door > start
    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        sec_cnt_d = sec_cnt_q;
        phase_d   = phase_q;
        case (state_q)
            IDLE: begin
                if (start_p && !door_open && !stage_empty(table_q[0])) begin
                    state_d   = LOAD;
                    stage_d   = '0;
                    sec_cnt_d = '0;
                end
            end
            LOAD: begin
                if (stop_p) begin
                    state_d = IDLE;
                    stage_d = '0;
                end else if (!door_open && tick) begin
                    if (sec_cnt_q == LOAD_LAST) begin
                        state_d = RUN;
                        phase_d = '0;
                    end else begin
                        sec_cnt_d = sec_cnt_q + SEC_W'(1);
                    end
                end
            end
            RUN: begin
                if (tick) begin
                    phase_d = (phase_q == (PWR_PERIOD - 4'd1)) ? 4'd0 : phase_q + 4'd1;
                end
                if (stop_p) begin
                    state_d = IDLE;
                    stage_d = '0;
                end else if (done_rise) begin
                    sec_cnt_d = '0;
                    if (has_next) begin
                        state_d = LOAD;
                        stage_d = next_idx;
                    end else begin
                        state_d = BEEP;
                    end
                end else if (pause_p || door_rise) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (stop_p) begin
                    state_d = IDLE;
                    stage_d = '0;
                end else if ((start_p || pause_p) && !door_open) begin
                    state_d = RUN;
                end
            end
            BEEP: begin
                if (stop_p) begin
                    state_d = IDLE;
                    stage_d = '0;
                end else if (tick) begin
                    if (sec_cnt_q == BEEP_LAST) begin
                        state_d = IDLE;
                        stage_d = '0;
                    end else begin
                        sec_cnt_d = sec_cnt_q + SEC_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                stage_d = '0;
            end
        endcase
    end

    // Output values derived from the transition being taken this cycle
    always_comb begin
        tmr_min_d   = tmr_min;
        tmr_sec_d   = tmr_sec;
        if (state_d == LOAD) begin
            tmr_min_d = table_q[stage_d].min;
            tmr_sec_d = table_q[stage_d].sec;
        end
        tmr_stop_d  = stop_p && ((state_q == LOAD) || (state_q == RUN) || (state_q == PAUSED));
        tmr_start_d = (state_d == RUN) && (state_q != RUN);
        tmr_pause_d = (state_q == RUN) && (state_d == PAUSED);
        mag_en_d    = (state_q == RUN) && (state_d == RUN) && !door_open &&
                      (phase_q < table_q[stage_q].pwr);
        beep_d      = (state_d == BEEP);
    end

endmodule

// File: tb/tb_cook_sequencer.sv
// Directed testbench for cook_sequencer with a short one-second tick.
module tb_cook_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       cfg_we;
    logic [1:0] cfg_idx;
    logic [6:0] cfg_min;
    logic [6:0] cfg_sec;
    logic [3:0] cfg_pwr;
    logic       start_p, pause_p, stop_p;
    logic       door_open, tmr_done;
    logic [6:0] tmr_min, tmr_sec;
    logic       tmr_start, tmr_pause, tmr_stop;
    logic       mag_en;
    logic [1:0] stage;
    logic       busy, beep;

    int checks = 0;
    int errors = 0;
    int n;
    int cnt;

    cook_sequencer #(
        .NUM_STAGES   (4),
        .TICKS_PER_SEC(4),
        .LOAD_WAIT_SEC(2),
        .BEEP_SEC     (3)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .cfg_we   (cfg_we),
        .cfg_idx  (cfg_idx),
        .cfg_min  (cfg_min),
        .cfg_sec  (cfg_sec),
        .cfg_pwr  (cfg_pwr),
        .start_p  (start_p),
        .pause_p  (pause_p),
        .stop_p   (stop_p),
        .door_open(door_open),
        .tmr_done (tmr_done),
        .tmr_min  (tmr_min),
        .tmr_sec  (tmr_sec),
        .tmr_start(tmr_start),
        .tmr_pause(tmr_pause),
        .tmr_stop (tmr_stop),
        .mag_en   (mag_en),
        .stage    (stage),
        .busy     (busy),
        .beep     (beep)
    );

    always #5 clock = ~clock;

    task automatic step(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic p, input logic st);
        start_p = s;
        pause_p = p;
        stop_p  = st;
        step(1);
        start_p = 1'b0;
        pause_p = 1'b0;
        stop_p  = 1'b0;
    endtask

    task automatic writeStage(input logic [1:0] idx, input logic [6:0] m,
                              input logic [6:0] s, input logic [3:0] p);
        cfg_we  = 1'b1;
        cfg_idx = idx;
        cfg_min = m;
        cfg_sec = s;
        cfg_pwr = p;
        step(1);
        cfg_we  = 1'b0;
    endtask

    task automatic waitStart(input string tag, output int cycles);
        cycles = 0;
        while (tmr_start !== 1'b1 && cycles < 40) begin
            step(1);
            cycles++;
        end
        checkOutput({tag, "_start_seen"}, tmr_start, 1);
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_min = '0; cfg_sec = '0;
        cfg_pwr = '0; start_p = 1'b0; pause_p = 1'b0; stop_p = 1'b0;
        door_open = 1'b0; tmr_done = 1'b0;
        step(3);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_pulses", {tmr_start, tmr_pause, tmr_stop, mag_en, beep}, 0);
        checkOutput("rst_time", {tmr_min, tmr_sec}, 0);
        checkOutput("rst_stage", stage, 0);
        reset = 1'b0;
        step(1);

        $display("[TB] two-stage program with beep");
        writeStage(2'd0, 7'd0, 7'd5, 4'd10);
        writeStage(2'd1, 7'd0, 7'd3, 4'd5);
        writeStage(2'd2, 7'd0, 7'd0, 4'd0);
        door_open = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("idle_door_open_ignored", busy, 0);
        door_open = 1'b0;
        step(1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("s0_busy", busy, 1);
        checkOutput("s0_tmr_sec", tmr_sec, 5);
        checkOutput("s0_stage", stage, 0);
        waitStart("s0", n);
        checkOutput("s0_load_len_5_to_8", (n >= 5 && n <= 8), 1);
        step(1);
        checkOutput("s0_start_single", tmr_start, 0);
        step(2);
        tmr_done = 1'b1;
        step(1);
        tmr_done = 1'b0;
        checkOutput("s1_stage", stage, 1);
        checkOutput("s1_tmr_sec", tmr_sec, 3);
        waitStart("s1", n);
        checkOutput("s1_load_len", n, 8);
        step(3);
        tmr_done = 1'b1;
        step(1);
        tmr_done = 1'b0;
        checkOutput("beep_on", beep, 1);
        n = 0;
        while (beep === 1'b1 && n < 40) begin
            step(1);
            n++;
        end
        checkOutput("beep_len", n, 12);
        checkOutput("beep_done_busy", busy, 0);
        checkOutput("beep_done_stage", stage, 0);

        $display("[TB] power level 3 duty cycle");
        writeStage(2'd0, 7'd10, 7'd0, 4'd3);
        writeStage(2'd1, 7'd0, 7'd0, 4'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitStart("pwr3", n);
        cnt = 0;
        for (int k = 0; k < 80; k++) begin
            if (mag_en === 1'b1) cnt++;
            if (k == 1)  checkOutput("pwr3_k1", mag_en, 1);
            if (k == 12) checkOutput("pwr3_k12", mag_en, 1);
            if (k == 13) checkOutput("pwr3_k13", mag_en, 0);
            if (k == 41) checkOutput("pwr3_k41", mag_en, 1);
            step(1);
        end
        checkOutput("pwr3_high_cycles", cnt, 24);

        $display("[TB] door interlock pause and resume");
        step(9);
        door_open = 1'b1;
        step(1);
        checkOutput("door_pause_pulse", tmr_pause, 1);
        checkOutput("door_mag_off", mag_en, 0);
        checkOutput("door_busy", busy, 1);
        start_p = 1'b1;
        step(1);
        start_p = 1'b0;
        checkOutput("door_start_ignored", tmr_start, 0);
        checkOutput("door_pause_single", tmr_pause, 0);
        door_open = 1'b0;
        step(1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("resume_start_pulse", tmr_start, 1);
        step(1);
        checkOutput("resume_phase2_mag_on", mag_en, 1);
        step(3);
        checkOutput("resume_phase3_mag_off", mag_en, 0);

        $display("[TB] stop and pause together");
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("stop_pulse", tmr_stop, 1);
        checkOutput("stop_no_pause", tmr_pause, 0);
        checkOutput("stop_busy", busy, 0);
        checkOutput("stop_stage", stage, 0);
        checkOutput("stop_beep", beep, 0);
        checkOutput("stop_mag", mag_en, 0);
        step(1);
        checkOutput("stop_single", tmr_stop, 0);

        $display("[TB] saturation and locked table");
        writeStage(2'd0, 7'd120, 7'd75, 4'd15);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("sat_min", tmr_min, 99);
        checkOutput("sat_sec", tmr_sec, 59);
        writeStage(2'd0, 7'd1, 7'd1, 4'd1);
        waitStart("sat", n);
        step(1);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (mag_en === 1'b1) cnt++;
            step(1);
        end
        checkOutput("sat_mag_always", cnt, 40);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("sat_stop_idle", busy, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("locked_min", tmr_min, 99);
        checkOutput("locked_sec", tmr_sec, 59);
        waitStart("locked", n);
        step(5);

        $display("[TB] reset mid-run");
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_pulses", {tmr_start, tmr_pause, tmr_stop, mag_en, beep}, 0);
        checkOutput("mid_rst_time", {tmr_min, tmr_sec}, 0);
        checkOutput("mid_rst_stage", stage, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("cleared_start_ignored", busy, 0);
        step(8);
        checkOutput("cleared_still_idle", busy, 0);
        checkOutput("cleared_no_start", tmr_start, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cook_sequencer.md
Name: cook_sequencer

Overview:
- Multi-stage cooking program controller sitting in front of the minute/second countdown timer.
- Holds a small table of stages (minutes, seconds, power level) and presents each stage's time to the timer. It pulses the timer's start/pause/stop controls, waits for the timer's done, then advances to the next stage.
- Generates the duty-cycled magnetron enable from the stage power level and enforces the door interlock.
- Ends each program with a timed beep.

Parameters:
- NUM_STAGES, 4, number of program stages; cfg_idx width is $clog2(NUM_STAGES).
- TICKS_PER_SEC, 100_000_000, clock cycles per internal 1 s tick.
- LOAD_WAIT_SEC, 2, whole seconds that tmr_min/tmr_sec are held stable before tmr_start is pulsed.
- BEEP_SEC, 3, seconds the beep output stays high at program end.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cfg_we  in  1  write the stage table entry selected by cfg_idx; ignored unless in IDLE
- cfg_idx  in  $clog2(NUM_STAGES)  stage index
- cfg_min  in  7  minutes; values ≥100 are stored as 99
- cfg_sec  in  7  seconds; values ≥60 are stored as 59
- cfg_pwr  in  4  power level 0..10; values >10 are stored as 10
- start_p  in  1  single-cycle pulse (already edge-detected) from the start button
- pause_p  in  1  single-cycle pulse from the pause button
- stop_p  in  1  single-cycle pulse from the stop button
- door_open  in  1  level, 1 = door open
- tmr_done  in  1  done level from the timer
- tmr_min  out  7  minutes presented to the timer
- tmr_sec  out  7  seconds presented to the timer
- tmr_start  out  1  one-cycle pulse to the timer
- tmr_pause  out  1  one-cycle pulse to the timer
- tmr_stop  out  1  one-cycle pulse to the timer
- mag_en  out  1  magnetron enable
- stage  out  $clog2(NUM_STAGES)  index of the current stage
- busy  out  1  high in any state other than IDLE
- beep  out  1  end-of-program beep

Behaviour:
- Reset (synchronous): state=IDLE, all outputs 0, stage table cleared to all zeros, tick prescaler and phase counter cleared. Reset mid-operation aborts with no tmr_stop pulse; the timer is reset by the same reset net.
- Tick: tick is a 1-cycle strobe when the prescaler reaches TICKS_PER_SEC-1. The prescaler free-runs and is never restarted by state changes.
- A stage is empty when min==0 and sec==0. A program ends at the first empty stage or after stage NUM_STAGES-1.
- State IDLE:
  - start_p with door closed and stage 0 non-empty → LOAD, stage=0.
  - start_p with door open or stage 0 empty → ignored.
- State LOAD:
  - tmr_min/tmr_sec = table[stage].
  - Count LOAD_WAIT_SEC ticks, then pulse tmr_start for one cycle and go to RUN with phase=0.
  - door_open during LOAD → stays in LOAD with the count frozen.
- State RUN:
  - On each tick, phase increments modulo 10.
  - mag_en = (phase < pwr) && !door_open, registered with 1-cycle latency. pwr=0 gives mag_en never high; pwr=10 gives mag_en always high.
  - Rising edge of tmr_done (registered compare) ends the stage: if the next stage exists and is non-empty, stage++ → LOAD; otherwise → BEEP.
  - pause_p or door_open rising edge → pulse tmr_pause → PAUSED.
- State PAUSED:
  - mag_en=0.
  - start_p or pause_p with door closed → pulse tmr_start → RUN, with phase kept.
  - start_p or pause_p with door open → ignored.
- State BEEP:
  - beep=1 for BEEP_SEC ticks, then IDLE with stage=0.
  - start_p or pause_p during BEEP → ignored.
- stop_p in LOAD, RUN or PAUSED: pulse tmr_stop, mag_en=0 the next cycle, go to IDLE with stage=0 and no beep. stop_p in BEEP clears beep and goes to IDLE.
- Priority for events in the same cycle: reset > stop_p > tmr_done edge > door_open/pause_p > start_p.
- At most one tmr_* pulse per cycle. tmr_min/tmr_sec hold their value outside LOAD.
- tmr_done rises when the timer is stopped, so tmr_done edges are only honoured in RUN.

Decomposition:
- Shared package holds:
  - state enum (IDLE, LOAD, RUN, PAUSED, BEEP);
  - constants MAX_MIN=99, MAX_SEC=59, MAX_PWR=10, PWR_PERIOD=10;
  - a stage record type {min[6:0], sec[6:0], pwr[3:0]}.
- One sub-module is natural: sec_tick_gen (parameterised prescaler that produces the 1-cycle tick).

Test Plan (TICKS_PER_SEC=4, LOAD_WAIT_SEC=2, BEEP_SEC=3):
1. Program the table {0:0:05 pwr 10, 0:0:03 pwr 5, empty}, start_p → LOAD holds tmr_sec=5 for 8 cycles, one tmr_start pulse. On a model tmr_done edge → stage=1, tmr_sec=3. After the second done: beep high 12 cycles, then IDLE, busy=0.
2. pwr=3 in RUN for 20 ticks → mag_en high for exactly 6 ticks, on phases 0–2 of each 10-tick period.
3. door_open asserted in RUN → one tmr_pause pulse, mag_en=0. start_p while the door is still open → no pulse. Close the door, start_p → one tmr_start pulse, RUN resumes with phase preserved.
4. stop_p and pause_p in the same RUN cycle → only tmr_stop pulses, IDLE, stage=0, beep stays 0.
5. cfg_we with min=120, sec=75, pwr=15 → stage presents tmr_min=99, tmr_sec=59, and mag_en stays constantly high. cfg_we while busy → table unchanged.
6. Synchronous reset asserted mid-RUN → next cycle all outputs 0, and a subsequent start_p is ignored because the table was cleared.
